// File: rtl/rc_window_sched.sv
// Round-robin owner of one compare_01 unit over WIN-sample handshaked windows.
// Reports the RC=1 count and majority flag per window, tagged with the owner.

module compare_01 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic [3:0] c,
   output logic       rc
);
   // RC=1 when the 5-bit sum A+B strictly exceeds C
   assign rc = ({1'b0, a} + {1'b0, b}) > {1'b0, c};
endmodule

module rc_window_sched #(
   parameter int WIN_LOG2 = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                r0_valid,
   input  logic [3:0]          r0_a,
   input  logic [3:0]          r0_b,
   input  logic [3:0]          r0_c,
   output logic                r0_ready,
   input  logic                r1_valid,
   input  logic [3:0]          r1_a,
   input  logic [3:0]          r1_b,
   input  logic [3:0]          r1_c,
   output logic                r1_ready,
   output logic                res_valid,
   input  logic                res_ready,
   output logic                res_id,
   output logic [WIN_LOG2:0]   res_n1,
   output logic                res_f,
   output logic                busy
);
   localparam int W = WIN_LOG2 + 1;
   localparam logic [W-1:0] WIN  = {1'b1, {WIN_LOG2{1'b0}}};
   localparam logic [W-1:0] HALF = WIN >> 1;
   localparam logic [W-1:0] ONE  = {{(W-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {IDLE, RUN, REPORT} state_t;

   state_t         state, state_nx;
   logic           grant, grant_nx;
   logic           last_grant, last_nx;
   logic [W-1:0]   cnt, cnt_nx, cnt_inc;
   logic [W-1:0]   n1, n1_nx, n1_inc;
   logic           res_id_nx, res_f_nx;
   logic [W-1:0]   res_n1_nx;
   logic [3:0]     cmp_a, cmp_b, cmp_c;
   logic           rc, accept;

   assign cmp_a = grant ? r1_a : r0_a;
   assign cmp_b = grant ? r1_b : r0_b;
   assign cmp_c = grant ? r1_c : r0_c;

   compare_01 u_cmp (
      .a  (cmp_a),
      .b  (cmp_b),
      .c  (cmp_c),
      .rc (rc)
   );

   assign r0_ready  = (state == RUN) && !grant;
   assign r1_ready  = (state == RUN) && grant;
   assign accept    = grant ? (r1_valid & r1_ready) : (r0_valid & r0_ready);
   assign cnt_inc   = cnt + ONE;
   assign n1_inc    = n1 + {{(W-1){1'b0}}, rc};
   assign res_valid = (state == REPORT);
   assign busy      = (state != IDLE);

   always_comb begin
      state_nx  = state;
      grant_nx  = grant;
      last_nx   = last_grant;
      cnt_nx    = cnt;
      n1_nx     = n1;
      res_id_nx = res_id;
      res_n1_nx = res_n1;
      res_f_nx  = res_f;
      unique case (state)
         IDLE: begin
            if (r0_valid || r1_valid) begin
               // contention goes to whoever did not win last time
               grant_nx = (r0_valid && r1_valid) ? ~last_grant : r1_valid;
               last_nx  = grant_nx;
               cnt_nx   = '0;
               n1_nx    = '0;
               state_nx = RUN;
            end
         end
         RUN: begin
            if (accept) begin
               cnt_nx = cnt_inc;
               n1_nx  = n1_inc;
               if (cnt_inc == WIN) begin
                  res_n1_nx = n1_inc;
                  res_f_nx  = n1_inc > HALF;
                  res_id_nx = grant;
                  state_nx  = REPORT;
               end
            end
         end
         REPORT: begin
            if (res_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         grant      <= 1'b0;
         last_grant <= 1'b1;
         cnt        <= '0;
         n1         <= '0;
         res_id     <= 1'b0;
         res_n1     <= '0;
         res_f      <= 1'b0;
      end else begin
         state      <= state_nx;
         grant      <= grant_nx;
         last_grant <= last_nx;
         cnt        <= cnt_nx;
         n1         <= n1_nx;
         res_id     <= res_id_nx;
         res_n1     <= res_n1_nx;
         res_f      <= res_f_nx;
      end
   end
endmodule

// File: tb/tb_rc_window_sched.sv
// Directed bench for rc_window_sched: WIN=8 window table plus WIN=256 counts.
// Expected RC values are hand-computed from RC = (A+B) > C.

module tb_rc_window_sched;
   typedef struct {
      logic [3:0] a, b, c;
   } op_t;

   typedef struct {
      bit         id;
      logic [7:0] rcs;
      bit         stall;
      bit         hold;
      int         n1;
      bit         f;
   } win_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;

   logic       r0_valid = 0, r1_valid = 0, res_ready = 0;
   logic [3:0] r0_a = 0, r0_b = 0, r0_c = 0;
   logic [3:0] r1_a = 0, r1_b = 0, r1_c = 0;
   logic       r0_ready, r1_ready, res_valid, res_id, res_f, busy;
   logic [3:0] res_n1;

   logic       p0_valid = 0, p1_valid = 0, p_res_ready = 1;
   logic [3:0] p0_a = 0, p0_b = 0, p0_c = 0;
   logic [3:0] p1_a = 0, p1_b = 0, p1_c = 0;
   logic       p0_ready, p1_ready, p_res_valid, p_res_id, p_res_f, p_busy;
   logic [8:0] p_res_n1;

   int errors = 0;
   int checks = 0;

   op_t rc1 [5];
   op_t rc0 [5];
   win_t tbl [7];

   always #5 clk = ~clk;

   rc_window_sched #(.WIN_LOG2(3)) dut (
      .clk(clk), .rst(rst),
      .r0_valid(r0_valid), .r0_a(r0_a), .r0_b(r0_b), .r0_c(r0_c),
      .r0_ready(r0_ready),
      .r1_valid(r1_valid), .r1_a(r1_a), .r1_b(r1_b), .r1_c(r1_c),
      .r1_ready(r1_ready),
      .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
      .res_n1(res_n1), .res_f(res_f), .busy(busy)
   );

   rc_window_sched dut8 (
      .clk(clk), .rst(rst),
      .r0_valid(p0_valid), .r0_a(p0_a), .r0_b(p0_b), .r0_c(p0_c),
      .r0_ready(p0_ready),
      .r1_valid(p1_valid), .r1_a(p1_a), .r1_b(p1_b), .r1_c(p1_c),
      .r1_ready(p1_ready),
      .res_valid(p_res_valid), .res_ready(p_res_ready), .res_id(p_res_id),
      .res_n1(p_res_n1), .res_f(p_res_f), .busy(p_busy)
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit id, input bit v, input op_t op);
      if (id) begin
         r0_valid = 0;
         r1_valid = v; r1_a = op.a; r1_b = op.b; r1_c = op.c;
      end else begin
         r1_valid = 0;
         r0_valid = v; r0_a = op.a; r0_b = op.b; r0_c = op.c;
      end
   endtask

   // Starts in IDLE; returns just after the edge of the last accept.
   task automatic run_win(input win_t w, input int n_acc,
                          output int acc, output int other_bad);
      int cyc;
      bit v, rdy, oth;
      op_t op;
      acc = 0;
      other_bad = 0;
      cyc = 0;
      res_ready = !w.hold;
      while (acc < n_acc && cyc < 200) begin
         v  = w.stall ? (cyc % 2 == 0) : 1'b1;
         op = w.rcs[acc % 8] ? rc1[acc % 5] : rc0[acc % 5];
         drive(w.id, v, op);
         #1;
         rdy = w.id ? r1_ready : r0_ready;
         oth = w.id ? r0_ready : r1_ready;
         if (oth) other_bad++;
         if (v && rdy) acc++;
         tick();
         cyc++;
      end
      r0_valid = 0;
      r1_valid = 0;
   endtask

   initial begin
      int acc, bad, nres, cyc;
      int ids [4];
      int n1s [4];
      bit early;

      rc1[0] = '{5, 6, 3};    rc1[1] = '{15, 15, 15};
      rc1[2] = '{8, 8, 15};   rc1[3] = '{0, 1, 0};
      rc1[4] = '{9, 0, 8};
      rc0[0] = '{2, 1, 9};    rc0[1] = '{0, 0, 0};
      rc0[2] = '{7, 8, 15};   rc0[3] = '{3, 4, 7};
      rc0[4] = '{0, 0, 15};

      tbl[0] = '{0, 8'hFF, 0, 0, 8, 1};
      tbl[1] = '{1, 8'h0F, 0, 0, 4, 0};
      tbl[2] = '{1, 8'h87, 0, 0, 4, 0};
      tbl[3] = '{1, 8'h8F, 0, 0, 5, 1};
      tbl[4] = '{0, 8'hA5, 1, 1, 4, 0};
      tbl[5] = '{0, 8'h00, 0, 0, 0, 0};
      tbl[6] = '{1, 8'h7F, 0, 0, 7, 1};

      tick();
      tick();
      chk("rst_r0_ready", r0_ready, 0);
      chk("rst_r1_ready", r1_ready, 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_res_n1", res_n1, 0);
      chk("rst_busy", busy, 0);
      rst = 0;

      for (int i = 0; i < 7; i++) begin
         run_win(tbl[i], 8, acc, bad);
         chk($sformatf("w%0d_accepts", i), acc, 8);
         chk($sformatf("w%0d_other_ready", i), bad, 0);
         chk($sformatf("w%0d_res_valid", i), res_valid, 1);
         chk($sformatf("w%0d_no_ready", i), r0_ready | r1_ready, 0);
         chk($sformatf("w%0d_res_id", i), res_id, tbl[i].id);
         chk($sformatf("w%0d_res_n1", i), res_n1, tbl[i].n1);
         chk($sformatf("w%0d_res_f", i), res_f, tbl[i].f);
         if (tbl[i].hold) begin
            for (int k = 0; k < 5; k++) begin
               tick();
               chk($sformatf("w%0d_hold%0d_valid", i, k), res_valid, 1);
               chk($sformatf("w%0d_hold%0d_n1", i, k), res_n1, tbl[i].n1);
               chk($sformatf("w%0d_hold%0d_id", i, k), res_id, tbl[i].id);
            end
            res_ready = 1;
         end
         tick();
         chk($sformatf("w%0d_idle_busy", i), busy, 0);
         chk($sformatf("w%0d_idle_valid", i), res_valid, 0);
      end

      // both requesters valid continuously from reset
      rst = 1;
      tick();
      rst = 0;
      res_ready = 1;
      r0_valid = 1; r0_a = 5; r0_b = 6; r0_c = 3;
      r1_valid = 1; r1_a = 0; r1_b = 1; r1_c = 0;
      nres = 0;
      bad = 0;
      cyc = 0;
      while (nres < 4 && cyc < 100) begin
         if (r0_ready && r1_ready) bad++;
         if (res_valid) begin
            ids[nres] = res_id;
            n1s[nres] = res_n1;
            nres++;
         end
         if (nres < 4) tick();
         cyc++;
      end
      r0_valid = 0;
      r1_valid = 0;
      chk("rr_results", nres, 4);
      chk("rr_both_ready", bad, 0);
      for (int k = 0; k < nres; k++) begin
         chk($sformatf("rr_id%0d", k), ids[k], k % 2);
         chk($sformatf("rr_n1_%0d", k), n1s[k], 8);
      end
      tick();
      chk("rr_idle", busy, 0);

      // abort a requester-0 window after its 5th accept
      run_win('{0, 8'hFF, 0, 0, 8, 1}, 5, acc, bad);
      chk("abort_accepts", acc, 5);
      rst = 1;
      tick();
      rst = 0;
      chk("abort_busy", busy, 0);
      chk("abort_res_valid", res_valid, 0);
      chk("abort_res_id", res_id, 0);
      chk("abort_res_n1", res_n1, 0);
      chk("abort_res_f", res_f, 0);
      chk("abort_ready", r0_ready | r1_ready, 0);
      r0_valid = 1; r0_a = 5; r0_b = 6; r0_c = 3;
      r1_valid = 1; r1_a = 5; r1_b = 6; r1_c = 3;
      tick();
      chk("post_rst_grant0", r0_ready, 1);
      chk("post_rst_no_grant1", r1_ready, 0);
      r1_valid = 0;
      early = 0;
      for (int k = 0; k < 8; k++) begin
         if (res_valid) early = 1;
         tick();
      end
      chk("post_rst_no_early", early, 0);
      chk("post_rst_res_valid", res_valid, 1);
      chk("post_rst_res_n1", res_n1, 8);
      r0_valid = 0;
      tick();

      // WIN=256: half ones, then all ones
      for (int w = 0; w < 2; w++) begin
         acc = 0;
         cyc = 0;
         while (acc < 256 && cyc < 600) begin
            p0_valid = 1;
            if (w == 1 || acc < 128) begin
               p0_a = 8; p0_b = 8; p0_c = 15;
            end else begin
               p0_a = 7; p0_b = 8; p0_c = 15;
            end
            #1;
            if (p0_ready) acc++;
            tick();
            cyc++;
         end
         p0_valid = 0;
         chk($sformatf("w256_%0d_accepts", w), acc, 256);
         chk($sformatf("w256_%0d_valid", w), p_res_valid, 1);
         chk($sformatf("w256_%0d_n1", w), p_res_n1, w ? 256 : 128);
         chk($sformatf("w256_%0d_f", w), p_res_f, w);
         chk($sformatf("w256_%0d_id", w), p_res_id, 0);
         tick();
         chk($sformatf("w256_%0d_idle", w), p_busy, 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end
endmodule
